// File: rtl/jk_bank_driver.sv
// Drives J/K excitation so an external JK flip-flop bank walks to a requested value,
// a few bits per cycle, while a shadow model checks the bank's q feedback.
module jk_bank_driver #(
  parameter int WIDTH      = 8,
  parameter int MAX_FLIPS  = 2,
  parameter int USE_TOGGLE = 0,
  parameter int CHECK_EN   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tgt_valid,
  output logic             tgt_ready,
  input  logic [WIDTH-1:0] tgt_data,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             busy,
  output logic             done,
  output logic             mismatch
);

  // Handshake: a target transfers on any rising edge where tgt_valid && tgt_ready;
  // tgt_ready is high exactly while IDLE and tgt_data is ignored otherwise.
  typedef enum logic {IDLE, APPLY} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] target, target_nxt;
  logic [WIDTH-1:0] shadow, shadow_nxt, shadow_d;
  logic [WIDTH-1:0] diff, sel;
  logic [WIDTH-1:0] j_nxt, k_nxt;
  logic             done_nxt;
  logic             post_rst;
  int               picked;

  assign diff      = target ^ shadow;
  assign tgt_ready = (state == IDLE);
  assign busy      = (state == APPLY);

  // Lowest-index differing bits first, capped at MAX_FLIPS per cycle.
  always_comb begin
    sel    = '0;
    picked = 0;
    for (int i = 0; i < WIDTH; i++) begin
      if (diff[i] && (picked < MAX_FLIPS)) begin
        sel[i] = 1'b1;
        picked = picked + 1;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    target_nxt = target;
    shadow_nxt = shadow;
    j_nxt      = '0;
    k_nxt      = '0;
    done_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (tgt_valid) begin
          target_nxt = tgt_data;
          state_nxt  = APPLY;
        end
      end
      APPLY: begin
        if (diff == '0) begin
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end else begin
          shadow_nxt = shadow ^ sel;
          if (USE_TOGGLE != 0) begin
            j_nxt = sel;
            k_nxt = sel;
          end else begin
            j_nxt = sel & target;
            k_nxt = sel & ~target;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      target   <= '0;
      shadow   <= '0;
      shadow_d <= '0;
      j        <= '0;
      k        <= '0;
      done     <= 1'b0;
      mismatch <= 1'b0;
      post_rst <= 1'b1;
    end else begin
      state    <= state_nxt;
      target   <= target_nxt;
      shadow   <= shadow_nxt;
      shadow_d <= shadow;
      j        <= j_nxt;
      k        <= k_nxt;
      done     <= done_nxt;
      post_rst <= 1'b0;
      // The bank applies j/k one edge after they appear, so shadow_d lines up with q_fb.
      if ((CHECK_EN != 0) && !post_rst && (q_fb != shadow_d))
        mismatch <= 1'b1;
    end
  end

endmodule

// File: doc/jk_bank_driver.md
Name: jk_bank_driver

Overview:
- Driver side of the JK flip-flop interface: it computes the J/K excitation needed to move an external bank of WIDTH JK flip-flops to a requested target value.
- Targets arrive on a valid/ready handshake and are applied over one or more cycles, at most MAX_FLIPS bits per cycle to limit simultaneous switching.
- The block keeps a shadow model of the bank, checks the bank's q outputs against it, and flags any divergence.

Parameters:
- WIDTH, 8, number of JK flip-flops in the driven bank (1..32)
- MAX_FLIPS, 2, maximum number of bits commanded to change per cycle (1..WIDTH)
- USE_TOGGLE, 0: 0 = changing bits use SET (j=1,k=0) or RESET (j=0,k=1) per target bit; 1 = changing bits use TOGGLE (j=1,k=1)
- CHECK_EN, 1: 1 = compare q_fb against the shadow model; 0 = mismatch tied to 0

Ports:
- clk  input  1  rising-edge clock, shared with the JK bank
- rst  input  1  synchronous active-high reset, shared with the JK bank (bank resets q=0)
- tgt_valid  input  1  target word offered
- tgt_ready  output  1  block can accept a target; equals (state==IDLE)
- tgt_data  input  WIDTH  requested bank value
- q_fb  input  WIDTH  q outputs of the JK bank
- j  output  WIDTH  registered J excitation, bit i drives FF i
- k  output  WIDTH  registered K excitation
- busy  output  1  high in APPLY
- done  output  1  one-cycle pulse: target reached, bank now commanded to target
- mismatch  output  1  sticky: q_fb differed from expected model

Behaviour:
- Reset (rst=1 at edge): state=IDLE, j=0, k=0, shadow=0, shadow_d=0, target reg=0, done=0, mismatch=0. After reset, tgt_ready=1 and busy=0. Reset mid-APPLY abandons the target with no done pulse.
- States:
  - IDLE: j=k=0 (HOLD). On tgt_valid&&tgt_ready at an edge: target<=tgt_data, state->APPLY.
  - APPLY, each edge:
    - diff = target ^ shadow.
    - If diff==0: j<=0, k<=0, done<=1, state->IDLE.
    - Else: sel = the MAX_FLIPS lowest-index set bits of diff (fewer if popcount(diff)<MAX_FLIPS).
    - For bits in sel: USE_TOGGLE=1 → j=1,k=1; USE_TOGGLE=0 → j=target[i], k=~target[i]. Bits not in sel → j=0,k=0.
    - shadow<=shadow^sel.
- done is high only in the cycle immediately after the APPLY→IDLE edge; otherwise 0. tgt_ready is high in that same cycle, so back-to-back targets are possible.
- Latency: with n = ceil(popcount(tgt_data^shadow)/MAX_FLIPS), done rises n+1 edges after the accepting edge. A target equal to the current shadow gives n=0, so done rises 1 edge after acceptance with no excitation issued.
- Bits already equal to target are never commanded. At most MAX_FLIPS bits of j|k are nonzero in any cycle.
- tgt_data is ignored while tgt_ready=0. The target register is not disturbed during APPLY.
- Check pipeline:
  - shadow_d<=shadow every edge.
  - In every cycle not immediately following reset, if CHECK_EN and q_fb!=shadow_d, then mismatch<=1 at the next edge.
  - mismatch stays set until rst.
  - q_fb reflects a command one edge after j/k present it. shadow_d provides that alignment.
- Shadow wraps nothing; it is a pure WIDTH-bit XOR model. The target register is WIDTH bits; no arithmetic.

Test Plan:
1. WIDTH=8, MAX_FLIPS=2, USE_TOGGLE=0, JK bank model attached, after reset: send 8'hFF.
   - Four APPLY commands: j=03,k=00 → j=0C → j=30 → j=C0.
   - done 5 edges after accept; q_fb=FF; mismatch=0.
2. From bank=FF, send 8'h0F.
   - Commands: k=30, then k=C0, with j=00.
   - done 3 edges after accept; q_fb=0F.
3. Send a target equal to the current value (8'h0F).
   - j=k=0 throughout; done 1 edge after accept; tgt_ready back high the same cycle.
4. USE_TOGGLE=1, from 00 send 8'h81.
   - One command j=k=81; done 2 edges after accept; q_fb=81.
5. Force q_fb bit3 wrong for one cycle during APPLY.
   - mismatch=1 next cycle and stays 1 across subsequent targets until rst.
6. Assert rst mid-APPLY of 8'hFF after the first command.
   - Next cycle: j=k=0, busy=0, tgt_ready=1, no done pulse, mismatch=0.
   - A following target 8'h01 then completes from shadow=0: j=01, done 2 edges after accept.
